// File: rtl/uart_tx_sequencer_pkg.sv
// Shared state encoding, parity-mode constant and parity helper for the UART transmit sequencer.
package uart_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP2,
        ST_STOP1,
        ST_BREAK
    } tx_state_t;

    localparam logic        PAR_EVEN = 1'b1;
    localparam int unsigned MIN_LEN  = 5;

    // xsum is the XOR of the data field; even mode sends it as-is, odd mode inverts it.
    function automatic logic calc_parity(input logic mode, input logic xsum);
        return (mode == PAR_EVEN) ? xsum : ~xsum;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Host-side write/status bundle between the eUSCI register logic and the transmit engine.
interface uart_tx_sequencer_if #(
    parameter int MAX_BITS = 8,
    parameter int DEPTH    = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                wr_en;
    logic [MAX_BITS-1:0] wr_data;
    logic                fifo_full;
    logic [LVL_W-1:0]    fifo_level;
    logic                wr_ovf;
    logic                set_txifg;
    logic                set_txcpt;

    modport master (
        output wr_en, wr_data,
        input  fifo_full, fifo_level, wr_ovf, set_txifg, set_txcpt
    );

    modport slave (
        input  wr_en, wr_data,
        output fifo_full, fifo_level, wr_ovf, set_txifg, set_txcpt
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO on BITCLK; head word is presented combinationally on rd_data.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         BITCLK,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge BITCLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge BITCLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// eUSCI UART transmit engine: FIFO-fed frame sequencer emitting one line bit per BITCLK edge,
// with latched per-frame configuration, parity, 1/2 stop bits and queued break frames.
module uart_tx_sequencer
    import uart_tx_sequencer_pkg::*;
#(
    parameter int MAX_BITS = 8,
    parameter int DEPTH    = 4
) (
    input  logic                            BITCLK,
    input  logic                            reset,
    uart_tx_sequencer_if.slave              bus,
    input  logic [$clog2(MAX_BITS+1)-1:0]   cfg_len,
    input  logic                            cfg_pen,
    input  logic                            cfg_par,
    input  logic                            cfg_msb,
    input  logic                            cfg_spb,
    input  logic                            brk_req,
    output logic                            tx,
    output logic                            busy
);
    localparam int LEN_W = $clog2(MAX_BITS + 1);
    localparam int LVL_W = $clog2(DEPTH + 1);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l < LEN_W'(MIN_LEN))  return LEN_W'(MIN_LEN);
        if (l > LEN_W'(MAX_BITS)) return LEN_W'(MAX_BITS);
        return l;
    endfunction

    function automatic logic [MAX_BITS-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [MAX_BITS-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_BITS; k++) begin
            if (k < int'(l)) m[k] = 1'b1;
        end
        return m;
    endfunction

    // Bit i of the data field in transmission order.
    function automatic logic data_bit(input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] l,
                                      input logic [LEN_W-1:0] i, input logic msb);
        logic [LEN_W-1:0] idx;
        logic             b;
        idx = msb ? (l - 1'b1 - i) : i;
        b   = 1'b0;
        for (int k = 0; k < MAX_BITS; k++) begin
            if (k == int'(idx)) b = d[k];
        end
        return b;
    endfunction

    tx_state_t           state;
    logic [MAX_BITS-1:0] shreg;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    len_l;
    logic [LEN_W-1:0]    len_req;
    logic                pen_l;
    logic                par_l;
    logic                msb_l;
    logic                spb_l;
    logic                brk_pend;
    logic                exit_point;
    logic                pop;
    logic [MAX_BITS-1:0] fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;

    uart_tx_fifo #(
        .W     (MAX_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .BITCLK  (BITCLK),
        .reset   (reset),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_level = fifo_level;

    assign len_req    = clamp_len(cfg_len);
    // IDLE and STOP1 both choose what goes on the line next: break first, then FIFO data.
    assign exit_point = (state == ST_IDLE) || (state == ST_STOP1);
    assign pop        = exit_point && !brk_pend && !fifo_empty;
    // Completion reflects the exit decision taken at the end of this STOP1 bit, so it is decoded here.
    assign bus.set_txcpt = (state == ST_STOP1) && !brk_pend && fifo_empty;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge BITCLK) begin
        if (pop) shreg <= fifo_head & len_mask(len_req);
    end

    always_ff @(posedge BITCLK or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            tx            <= 1'b1;
            cnt           <= '0;
            len_l         <= LEN_W'(MIN_LEN);
            pen_l         <= 1'b0;
            par_l         <= 1'b0;
            msb_l         <= 1'b0;
            spb_l         <= 1'b0;
            brk_pend      <= 1'b0;
            bus.set_txifg <= 1'b0;
            bus.wr_ovf    <= 1'b0;
        end else begin
            bus.set_txifg <= 1'b0;
            bus.wr_ovf    <= bus.wr_en && fifo_full;
            if (brk_req) brk_pend <= 1'b1;

            case (state)
                ST_IDLE, ST_STOP1: begin
                    len_l <= len_req;
                    pen_l <= cfg_pen;
                    par_l <= cfg_par;
                    msb_l <= cfg_msb;
                    spb_l <= cfg_spb;
                    if (brk_pend) begin
                        state    <= ST_BREAK;
                        tx       <= 1'b0;
                        cnt      <= '0;
                        brk_pend <= brk_req;
                    end else if (!fifo_empty) begin
                        state         <= ST_START;
                        tx            <= 1'b0;
                        bus.set_txifg <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_DATA;
                    cnt   <= '0;
                    tx    <= data_bit(shreg, len_l, '0, msb_l);
                end
                ST_DATA: begin
                    if (cnt == len_l - 1'b1) begin
                        if (pen_l) begin
                            state <= ST_PARITY;
                            tx    <= calc_parity(par_l, ^shreg);
                        end else begin
                            state <= spb_l ? ST_STOP2 : ST_STOP1;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        tx  <= data_bit(shreg, len_l, cnt + 1'b1, msb_l);
                    end
                end
                ST_PARITY: begin
                    state <= spb_l ? ST_STOP2 : ST_STOP1;
                    tx    <= 1'b1;
                end
                ST_STOP2: begin
                    state <= ST_STOP1;
                    tx    <= 1'b1;
                end
                ST_BREAK: begin
                    // Line held low for the start + data + parity span of the latched format.
                    if (cnt == len_l + LEN_W'(pen_l)) begin
                        state <= ST_STOP1;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: directed frames plus randomized formats against a frame-level line model.
module tb_uart_tx_sequencer;
    localparam int MAX_BITS = 8;
    localparam int DEPTH    = 4;
    localparam int LEN_W    = 4;

    logic             BITCLK = 1'b0;
    logic             reset;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_pen, cfg_par, cfg_msb, cfg_spb, brk_req;
    logic             tx, busy;

    uart_tx_sequencer_if #(.MAX_BITS(MAX_BITS), .DEPTH(DEPTH)) bus ();

    uart_tx_sequencer #(.MAX_BITS(MAX_BITS), .DEPTH(DEPTH)) dut (
        .BITCLK  (BITCLK),
        .reset   (reset),
        .bus     (bus),
        .cfg_len (cfg_len),
        .cfg_pen (cfg_pen),
        .cfg_par (cfg_par),
        .cfg_msb (cfg_msb),
        .cfg_spb (cfg_spb),
        .brk_req (brk_req),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 BITCLK = ~BITCLK;

    int checks = 0;
    int errors = 0;

    logic cap_tx[$], cap_ifg[$], cap_cpt[$];
    logic exp_tx[$], exp_ifg[$], exp_cpt[$];

    // ---------------- line model ----------------
    function automatic int eff_len(input int l);
        return (l < 5) ? 5 : ((l > MAX_BITS) ? MAX_BITS : l);
    endfunction

    function automatic void add_bit(input logic b, input logic ifg);
        exp_tx.push_back(b);
        exp_ifg.push_back(ifg);
        exp_cpt.push_back(1'b0);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add_bit(1'b1, 1'b0);
    endfunction

    function automatic void add_frame(input int d, input int len, input bit pen, input bit even,
                                      input bit msb, input bit spb);
        int l;
        int ones;
        int k;
        l    = eff_len(len);
        ones = 0;
        add_bit(1'b0, 1'b1);
        for (int i = 0; i < l; i++) begin
            k = msb ? (l - 1 - i) : i;
            add_bit(((d >> k) & 1) != 0, 1'b0);
            ones += (d >> i) & 1;
        end
        if (pen) add_bit(even ? (ones % 2 == 1) : (ones % 2 == 0), 1'b0);
        add_bit(1'b1, 1'b0);
        if (spb) add_bit(1'b1, 1'b0);
    endfunction

    function automatic void add_break(input int len, input bit pen);
        for (int i = 0; i < eff_len(len) + 1 + int'(pen); i++) add_bit(1'b0, 1'b0);
        add_bit(1'b1, 1'b0);
    endfunction

    function automatic void mark_cpt();
        exp_cpt[exp_cpt.size() - 1] = 1'b1;
    endfunction

    function automatic void clear_all();
        exp_tx.delete(); exp_ifg.delete(); exp_cpt.delete();
        cap_tx.delete(); cap_ifg.delete(); cap_cpt.delete();
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge BITCLK);
        #1;
        cap_tx.push_back(tx);
        cap_ifg.push_back(bus.set_txifg);
        cap_cpt.push_back(bus.set_txcpt);
    endtask

    task automatic push(input logic [MAX_BITS-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic set_cfg(input int len, input bit pen, input bit par, input bit msb, input bit spb);
        cfg_len = LEN_W'(len);
        cfg_pen = pen;
        cfg_par = par;
        cfg_msb = msb;
        cfg_spb = spb;
    endtask

    task automatic finish_capture();
        while (cap_tx.size() < exp_tx.size()) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_data = '0; brk_req = 1'b0;
        set_cfg(8, 0, 0, 0, 0);
        tick(); tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
        checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.fifo_full); end
        checks++; if ({bus.set_txifg, bus.set_txcpt, bus.wr_ovf} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b%b%b want 000", bus.set_txifg, bus.set_txcpt, bus.wr_ovf);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lsb_basic();
        logic want[10];
        want = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        set_cfg(8, 0, 0, 0, 0);
        clear_all();
        push(8'hA5);
        for (int i = 0; i < 11; i++) tick();
        checks++; if (cap_tx[0] !== 1'b1) begin errors++; $display("FAIL lsb_latency tx after push got %b want 1", cap_tx[0]); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cap_tx[i + 1] !== want[i]) begin
                errors++; $display("FAIL lsb_bit%0d got %b want %b", i, cap_tx[i + 1], want[i]);
            end
        end
        checks++; if (cap_ifg[1] !== 1'b1) begin errors++; $display("FAIL lsb_txifg at start got %b want 1", cap_ifg[1]); end
        checks++; if (cap_cpt[10] !== 1'b1) begin errors++; $display("FAIL lsb_txcpt at stop got %b want 1", cap_cpt[10]); end
        checks++; if (cap_tx[11] !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL lsb_idle tx=%b busy=%b want tx=1 busy=0", cap_tx[11], busy);
        end
    endtask

    task automatic test_msb_parity();
        logic want[10];
        want = '{0, 1, 0, 1, 0, 0, 1, 1, 0, 1};
        set_cfg(7, 1, 1, 1, 0);
        clear_all();
        push(8'h53);
        for (int i = 0; i < 11; i++) tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cap_tx[i + 1] !== want[i]) begin
                errors++; $display("FAIL msbpar_bit%0d got %b want %b", i, cap_tx[i + 1], want[i]);
            end
        end
        checks++; if (cap_cpt[10] !== 1'b1) begin errors++; $display("FAIL msbpar_txcpt got %b want 1", cap_cpt[10]); end
    endtask

    task automatic test_back_to_back();
        int d[6];
        set_cfg(8, 0, 0, 0, 0);
        clear_all();
        add_idle(1);
        for (int i = 0; i < 6; i++) d[i] = $urandom_range(0, 255);
        for (int i = 0; i < 5; i++) add_frame(d[i], 8, 0, 0, 0, 0);
        mark_cpt();
        add_idle(2);
        for (int i = 0; i < 5; i++) push(d[i][MAX_BITS-1:0]);
        checks++; if (bus.fifo_full !== 1'b1 || bus.fifo_level !== 3'd4) begin
            errors++; $display("FAIL b2b_full full=%b level=%0d want 1/4", bus.fifo_full, bus.fifo_level);
        end
        push(d[5][MAX_BITS-1:0]);
        checks++; if (bus.wr_ovf !== 1'b1) begin errors++; $display("FAIL b2b_ovf got %b want 1", bus.wr_ovf); end
        checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level_after_ovf got %0d want 4", bus.fifo_level); end
        tick();
        checks++; if (bus.wr_ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf_pulse got %b want 0", bus.wr_ovf); end
        finish_capture();
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_ifg[i] !== exp_ifg[i] || cap_cpt[i] !== exp_cpt[i]) begin
                errors++;
                $display("FAIL b2b_stream idx %0d tx/ifg/cpt got %b%b%b want %b%b%b", i,
                         cap_tx[i], cap_ifg[i], cap_cpt[i], exp_tx[i], exp_ifg[i], exp_cpt[i]);
            end
        end
    endtask

    task automatic test_break();
        int a, b;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        set_cfg(8, 1, 1, 0, 1);
        clear_all();
        add_idle(1);
        add_frame(a, 8, 1, 1, 0, 1);
        add_break(8, 1);
        add_frame(b, 8, 1, 1, 0, 1);
        mark_cpt();
        add_idle(2);
        push(a[MAX_BITS-1:0]);
        push(b[MAX_BITS-1:0]);
        tick(); tick();
        brk_req = 1'b1;
        tick();
        brk_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy got %b want 1", busy); end
        finish_capture();
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_ifg[i] !== exp_ifg[i] || cap_cpt[i] !== exp_cpt[i]) begin
                errors++;
                $display("FAIL brk_stream idx %0d tx/ifg/cpt got %b%b%b want %b%b%b", i,
                         cap_tx[i], cap_ifg[i], cap_cpt[i], exp_tx[i], exp_ifg[i], exp_cpt[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        set_cfg(8, 0, 0, 0, 0);
        clear_all();
        push(8'h3C);
        push(8'hC3);
        tick(); tick(); tick(); tick();
        checks++; if (tx !== 1'b1 || bus.fifo_level !== 3'd1) begin
            errors++; $display("FAIL rstmid_pre tx=%b level=%0d want 1/1", tx, bus.fifo_level);
        end
        reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
        checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_level got %0d want 0", bus.fifo_level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if ({bus.set_txifg, bus.set_txcpt, bus.wr_ovf} !== 3'b000) begin
            errors++; $display("FAIL rstmid_pulses got %b%b%b want 000", bus.set_txifg, bus.set_txcpt, bus.wr_ovf);
        end
        reset = 1'b0;
        c = $urandom_range(0, 255);
        clear_all();
        add_idle(1);
        add_frame(c, 8, 0, 0, 0, 0);
        mark_cpt();
        add_idle(2);
        push(c[MAX_BITS-1:0]);
        finish_capture();
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_ifg[i] !== exp_ifg[i] || cap_cpt[i] !== exp_cpt[i]) begin
                errors++;
                $display("FAIL rstmid_stream idx %0d tx/ifg/cpt got %b%b%b want %b%b%b", i,
                         cap_tx[i], cap_ifg[i], cap_cpt[i], exp_tx[i], exp_ifg[i], exp_cpt[i]);
            end
        end
    endtask

    task automatic test_cfg_change();
        int a, b;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        set_cfg(8, 0, 0, 0, 0);
        clear_all();
        add_idle(1);
        add_frame(a, 8, 0, 0, 0, 0);
        add_frame(b, 5, 0, 0, 0, 0);
        mark_cpt();
        add_idle(2);
        push(a[MAX_BITS-1:0]);
        push(b[MAX_BITS-1:0]);
        tick(); tick();
        cfg_len = LEN_W'(5);
        finish_capture();
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++;
            if (cap_tx[i] !== exp_tx[i] || cap_ifg[i] !== exp_ifg[i] || cap_cpt[i] !== exp_cpt[i]) begin
                errors++;
                $display("FAIL cfgchg_stream idx %0d tx/ifg/cpt got %b%b%b want %b%b%b", i,
                         cap_tx[i], cap_ifg[i], cap_cpt[i], exp_tx[i], exp_ifg[i], exp_cpt[i]);
            end
        end
    endtask

    task automatic test_random();
        int len, n;
        bit pen, par, msb, spb;
        int d[3];
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(0, 15);
            pen = 1'($urandom_range(0, 1));
            par = 1'($urandom_range(0, 1));
            msb = 1'($urandom_range(0, 1));
            spb = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 3);
            set_cfg(len, pen, par, msb, spb);
            clear_all();
            add_idle(1);
            for (int k = 0; k < n; k++) begin
                d[k] = $urandom_range(0, 255);
                add_frame(d[k], len, pen, par, msb, spb);
            end
            mark_cpt();
            add_idle(2);
            for (int k = 0; k < n; k++) push(d[k][MAX_BITS-1:0]);
            finish_capture();
            for (int i = 0; i < exp_tx.size(); i++) begin
                checks++;
                if (cap_tx[i] !== exp_tx[i] || cap_ifg[i] !== exp_ifg[i] || cap_cpt[i] !== exp_cpt[i]) begin
                    errors++;
                    $display("FAIL rand%0d_stream len=%0d pen=%b par=%b msb=%b spb=%b idx %0d got %b%b%b want %b%b%b",
                             it, len, pen, par, msb, spb, i,
                             cap_tx[i], cap_ifg[i], cap_cpt[i], exp_tx[i], exp_ifg[i], exp_cpt[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsb_basic();
        test_msb_parity();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        test_cfg_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
